// File: rtl/strassen_operand_loader_if.sv
// Stream and operand bus between the element source, the operand loader and the
// Strassen compute stage.
interface strassen_operand_loader_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic [7:0]         load_en;
  logic [4*WIDTH-1:0] op_a;
  logic [4*WIDTH-1:0] op_b;
  logic               out_valid;
  logic               out_ready;
  logic               err_framing;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, load_en, op_a, op_b, out_valid, err_framing
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, load_en, op_a, op_b, out_valid, err_framing
  );
endinterface

// File: rtl/strassen_operand_loader.sv
// Collects eight streamed matrix elements (a11..a22, b11..b22) into the operand
// bank and hands the complete A/B frame to the compute stage.
module strassen_operand_loader #(
  parameter int WIDTH = 8
) (
  input logic                    Clk,
  input logic                    Rst,
  strassen_operand_loader_if.slave bus
);

  typedef enum logic {LOAD, HOLD} state_t;

  state_t           state;
  logic [2:0]       idx;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             err_r;
  logic             accept;
  logic [7:0]       load_en;
  logic [WIDTH-1:0] slot [8];
  logic [4*WIDTH-1:0] op_a;
  logic [4*WIDTH-1:0] op_b;

  assign accept = bus.in_valid & in_ready_r & (state == LOAD);

  always_comb begin
    load_en = '0;
    if (accept) load_en[idx] = 1'b1;
  end

  // Operand bank: each slot is an enable flop written only by its own load enable.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < 8; k++) slot[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (load_en[k]) slot[k] <= bus.in_data;
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < 4; k++) begin
      op_a[WIDTH*k +: WIDTH] = slot[k];
      op_b[WIDTH*k +: WIDTH] = slot[4+k];
    end
  end

  // in_ready stays low for the first cycle after reset release, then tracks LOAD.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= LOAD;
      idx         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready_r <= 1'b1;
          if (accept) begin
            if (idx == 3'd7) begin
              state       <= HOLD;
              idx         <= '0;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              if (!bus.in_last) err_r <= 1'b1;
            end else if (bus.in_last) begin
              idx   <= '0;
              err_r <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= LOAD;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.err_framing = err_r;
  assign bus.load_en     = load_en;
  assign bus.op_a        = op_a;
  assign bus.op_b        = op_b;

endmodule

// File: tb/tb_strassen_operand_loader.sv
// Directed bench for strassen_operand_loader: frame fill, hold, gapped input,
// framing errors and asynchronous reset.
module tb_strassen_operand_loader;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  strassen_operand_loader_if #(.WIDTH(8)) bus ();

  strassen_operand_loader #(.WIDTH(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drives one element for one cycle and checks the slot enable it should raise.
  task automatic apply_stimulus(input logic [7:0] data, input bit last, input int exp_idx);
    logic [7:0] one_hot;
    one_hot         = 8'h01 << exp_idx;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    #1;
    check_output("load_en", 64'(bus.load_en), 64'(one_hot));
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_output("out_valid_after_hs", 64'(bus.out_valid), 64'd0);
    check_output("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check_output("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_op_a", 64'(bus.op_a), 64'd0);
    check_output("rst_op_b", 64'(bus.op_b), 64'd0);
    check_output("rst_err", 64'(bus.err_framing), 64'd0);
    check_output("rst_load_en", 64'(bus.load_en), 64'd0);
    Rst = 1'b0;
    tick();
    check_output("in_ready_release", 64'(bus.in_ready), 64'd1);

    // Back-to-back frame 0x11..0x88
    for (int k = 0; k < 8; k++)
      apply_stimulus(8'(8'h11 * (k + 1)), k == 7, k);
    check_output("f1_out_valid", 64'(bus.out_valid), 64'd1);
    check_output("f1_in_ready", 64'(bus.in_ready), 64'd0);
    check_output("f1_op_a", 64'(bus.op_a), 64'h44332211);
    check_output("f1_op_b", 64'(bus.op_b), 64'h88776655);
    check_output("f1_err", 64'(bus.err_framing), 64'd0);

    // HOLD with out_ready low; in_valid must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_output("hold_load_en", 64'(bus.load_en), 64'd0);
      check_output("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check_output("hold_op_a", 64'(bus.op_a), 64'h44332211);
      check_output("hold_op_b", 64'(bus.op_b), 64'h88776655);
      tick();
    end
    bus.in_valid = 1'b0;
    handshake();

    // Gapped frame 0xA0..0xA7, valid every other cycle
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(8'(8'hA0 + k), k == 7, k);
      if (k < 7) begin
        check_output("gap_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
      end
    end
    check_output("gap_out_valid_end", 64'(bus.out_valid), 64'd1);
    check_output("gap_op_a", 64'(bus.op_a), 64'hA3A2A1A0);
    check_output("gap_op_b", 64'(bus.op_b), 64'hA7A6A5A4);
    handshake();

    // Early in_last on 3rd element: partial frame discarded
    apply_stimulus(8'h01, 1'b0, 0);
    apply_stimulus(8'h02, 1'b0, 1);
    apply_stimulus(8'h03, 1'b1, 2);
    check_output("early_err", 64'(bus.err_framing), 64'd1);
    check_output("early_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("early_in_ready", 64'(bus.in_ready), 64'd1);
    check_output("early_op_a", 64'(bus.op_a), 64'hA3030201);
    for (int k = 0; k < 8; k++)
      apply_stimulus(8'(8'hB0 + k), k == 7, k);
    check_output("rec_out_valid", 64'(bus.out_valid), 64'd1);
    check_output("rec_op_a", 64'(bus.op_a), 64'hB3B2B1B0);
    check_output("rec_op_b", 64'(bus.op_b), 64'hB7B6B5B4);
    handshake();

    // 8th element without in_last: frame still completes
    for (int k = 0; k < 8; k++)
      apply_stimulus(8'(8'hC0 + k), 1'b0, k);
    check_output("nolast_out_valid", 64'(bus.out_valid), 64'd1);
    check_output("nolast_err", 64'(bus.err_framing), 64'd1);
    check_output("nolast_op_b", 64'(bus.op_b), 64'hC7C6C5C4);
    handshake();
    for (int k = 0; k < 8; k++)
      apply_stimulus(8'(8'hD0 + k), k == 7, k);
    check_output("sticky_err", 64'(bus.err_framing), 64'd1);
    check_output("clean_op_a", 64'(bus.op_a), 64'hD3D2D1D0);
    handshake();

    // Reset mid-frame after 5 elements
    for (int k = 0; k < 5; k++)
      apply_stimulus(8'(8'hE0 + k), 1'b0, k);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    Rst = 1'b1;
    #1;
    check_output("mid_rst_op_a", 64'(bus.op_a), 64'd0);
    check_output("mid_rst_op_b", 64'(bus.op_b), 64'd0);
    check_output("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("mid_rst_load_en", 64'(bus.load_en), 64'd0);
    check_output("mid_rst_err", 64'(bus.err_framing), 64'd0);
    check_output("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    Rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check_output("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 8; k++)
      apply_stimulus(8'(8'hF0 + k), k == 7, k);
    check_output("fresh_out_valid", 64'(bus.out_valid), 64'd1);
    check_output("fresh_op_a", 64'(bus.op_a), 64'hF3F2F1F0);
    check_output("fresh_op_b", 64'(bus.op_b), 64'hF7F6F5F4);
    check_output("fresh_err", 64'(bus.err_framing), 64'd0);

    // Reset while holding a frame drops out_valid without a clock edge
    #2;
    Rst = 1'b1;
    #1;
    check_output("hold_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("hold_rst_op_a", 64'(bus.op_a), 64'd0);
    tick();
    Rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/strassen_operand_loader.md
# strassen_operand_loader

Operand loading stage for the Strassen 2x2 multiplier. Accepts one WIDTH-bit matrix element per handshake on a valid/ready stream, steers each into its slot of the operand register bank (enable flip-flops, one load enable per element), and, once all eight elements of A and B are captured, presents them in parallel to the Strassen compute stage under a valid/ready handshake. It sits directly upstream of the operand register bank and the compute datapath.

## Interface
- WIDTH, 8, bits per matrix element
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream element valid
- in_ready  out  1  loader can accept an element
- in_data  in  WIDTH  element value
- in_last  in  1  marks final (8th) element of a frame
- load_en  out  8  one-hot per-element load enable to register bank, bit k = element k
- op_a  out  4*WIDTH  A elements; op_a[WIDTH*k +: WIDTH] = element k (k=0..3: a11,a12,a21,a22)
- op_b  out  4*WIDTH  B elements; op_b[WIDTH*k +: WIDTH] = element 4+k (b11,b12,b21,b22)
- out_valid  out  1  op_a/op_b hold a complete frame
- out_ready  in  1  compute stage accepts the frame
- err_framing  out  1  sticky framing error flag

## Operation
- Element order fixed: index 0..7 = a11,a12,a21,a22,b11,b12,b21,b22.
- State machine, two states:
  - LOAD: in_ready=1, out_valid=0. Accept = in_valid & in_ready. On accept, element written to slot idx, idx increments.
  - HOLD: in_ready=0, out_valid=1, op_a/op_b stable. On out_valid & out_ready -> LOAD, idx=0.
- LOAD -> HOLD on accept with idx==7 (frame complete regardless of in_last).
- load_en[k] = accept & (idx==k), combinational; at most one bit high; all zero in HOLD and during reset.
- Framing rules:
  - accept with in_last=1 and idx<7: element written to slot idx, err_framing set, idx forced to 0, stay in LOAD (partial frame discarded, bank contents stale but out_valid not raised).
  - accept with idx==7 and in_last=0: element written, err_framing set, frame still completes -> HOLD.
  - err_framing sticky until Rst.
- op_a/op_b not cleared between frames; slots overwritten only by load_en.
- in_valid ignored in HOLD; in_data not sampled.
- out_ready ignored in LOAD.

## Timing
- Reset values: state LOAD, idx 0, op_a 0, op_b 0, err_framing 0, out_valid 0, load_en 0, in_ready 0 while Rst high, 1 from first cycle after release.
- Write latency: element accepted at edge n is visible on op_a/op_b after edge n.
- out_valid rises on the edge that accepts element 7 (visible next cycle); minimum 8 cycles frame fill.
- in_ready rises the cycle after the out handshake edge; one-cycle bubble between frames; minimum period 9 cycles with out_ready held high.
- Back-to-back elements: one per cycle while in LOAD, no stall.
- Rst mid-frame or in HOLD: immediate clear of all state; partial/pending frame lost, out_valid drops asynchronously.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
- Reset release, 8 consecutive elements 0x11..0x88, in_last on 8th, out_ready=0 -> out_valid=1 next cycle, op_a=0x44332211, op_b=0x88776655, in_ready=0, load_en walked 0x01..0x80 one per cycle.
- Hold out_ready low 5 cycles then pulse -> op_a/op_b stable throughout, in_ready=1 cycle after handshake, idx restarts at a11.
- Gapped in_valid (valid every other cycle) -> same result as back-to-back, out_valid after 8th accept only.
- in_last on 3rd element -> err_framing=1, out_valid stays 0, next 8-element frame loads from slot 0 correctly.
- 8th element without in_last -> frame completes (out_valid=1), err_framing=1 and remains set through later clean frames.
- Assert Rst after 5 elements -> op_a/op_b=0, out_valid=0, load_en=0 immediately; fresh frame after release loads normally.
